// File: rtl/sd_seq_source.sv
// srdy/drdy stimulus producer: registered incrementing data with a programmable transfer count.
// Optional LFSR throttle on starting/continuing words is compiled in with SD_SEQ_THROTTLE_EN.
module sd_seq_source #(
   parameter int unsigned width       = 16,
   parameter int unsigned cnt_width   = 32,
   parameter int unsigned start_value = 0,
   parameter logic [15:0] lfsr_seed   = 16'hACE1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [cnt_width-1:0] max_count,
`ifdef SD_SEQ_THROTTLE_EN
   input  logic [3:0]           throttle,
`endif
   output logic                 p_srdy,
   input  logic                 p_drdy,
   output logic [width-1:0]     p_data,
   output logic [cnt_width-1:0] out_count,
   output logic                 done
);

   typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

   state_e               state_q, state_d;
   logic [width-1:0]     data_q, data_d;
   logic [cnt_width-1:0] count_q, count_d;
   logic [cnt_width:0]   count_inc;
   logic                 gate;
   logic                 xfer;
   logic                 limit_hit;
   logic                 last_xfer;

`ifdef SD_SEQ_THROTTLE_EN
   logic [15:0] lfsr_q;

   // Fibonacci LFSR, taps 16,14,13,11; free-running so gaps are independent of traffic.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) lfsr_q <= lfsr_seed;
      else       lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end

   assign gate = (lfsr_q[3:0] >= throttle);
`else
   assign gate = 1'b1;
`endif

   assign xfer      = (state_q == StSend) && p_drdy;
   assign limit_hit = (max_count != '0) && (count_q >= max_count);
   // Compare on the unsaturated increment so the terminal transfer is exact.
   assign count_inc = {1'b0, count_q} + (cnt_width + 1)'(1);
   assign last_xfer = (max_count != '0) && (count_inc == {1'b0, max_count});

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         data_q  <= width'(start_value);
         count_q <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (limit_hit)            state_d = StDone;
            else if (enable && gate)  state_d = StSend;
         end
         StSend: begin
            if (xfer) begin
               if (last_xfer)             state_d = StDone;
               else if (!(enable && gate)) state_d = StIdle;
            end
         end
         StDone:  state_d = StDone;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      data_d  = data_q;
      count_d = count_q;
      if (xfer) begin
         data_d = data_q + width'(1);
         if (!(&count_q)) count_d = count_q + cnt_width'(1);
      end
   end

   assign p_srdy    = (state_q == StSend);
   assign done      = (state_q == StDone);
   assign p_data    = data_q;
   assign out_count = count_q;

endmodule

// File: tb/tb_sd_seq_source.sv
// Directed and random checks of sd_seq_source against a cycle-level protocol model.
module tb_sd_seq_source;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        p_drdy;
   logic [31:0] max_count;
   logic        p_srdy;
   logic [15:0] p_data;
   logic [31:0] out_count;
   logic        done;

   logic        w_enable;
   logic        w_drdy;
   logic [7:0]  w_max;
   logic        w_srdy;
   logic [3:0]  w_data;
   logic [7:0]  w_count;
   logic        w_done;

   int total = 0;
   int bad   = 0;

   // model state
   logic            m_srdy;
   logic [15:0]     m_data;
   longint unsigned m_cnt;
   logic            m_done;

   always #5 clk = ~clk;

   sd_seq_source u_dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .max_count (max_count),
`ifdef SD_SEQ_THROTTLE_EN
      .throttle  (4'd0),
`endif
      .p_srdy    (p_srdy),
      .p_drdy    (p_drdy),
      .p_data    (p_data),
      .out_count (out_count),
      .done      (done)
   );

   sd_seq_source #(.width(4), .cnt_width(8), .start_value(14)) u_wrap (
      .clk       (clk),
      .reset     (reset),
      .enable    (w_enable),
      .max_count (w_max),
`ifdef SD_SEQ_THROTTLE_EN
      .throttle  (4'd0),
`endif
      .p_srdy    (w_srdy),
      .p_drdy    (w_drdy),
      .p_data    (w_data),
      .out_count (w_count),
      .done      (w_done)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_srdy = 1'b0; m_data = 16'd0; m_cnt = 0; m_done = 1'b0;
   endtask

   // Advance the model by one clock using the inputs currently applied.
   task automatic model_step();
      longint unsigned nc;
      if (m_done) begin
      end else if (!m_srdy) begin
         if (max_count != 0 && m_cnt >= max_count) m_done = 1'b1;
         else if (enable) m_srdy = 1'b1;
      end else if (p_drdy) begin
         nc     = m_cnt + 1;
         m_data = m_data + 16'd1;
         m_cnt  = (nc > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : nc;
         if (max_count != 0 && nc == max_count) begin
            m_srdy = 1'b0; m_done = 1'b1;
         end else if (!enable) m_srdy = 1'b0;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".srdy"}, 64'(p_srdy), 64'(m_srdy));
      chk({tag, ".data"}, 64'(p_data), 64'(m_data));
      chk({tag, ".count"}, 64'(out_count), m_cnt);
      chk({tag, ".done"}, 64'(done), 64'(m_done));
   endtask

   task automatic tick(input string tag);
      model_step();
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      check_all("reset");
   endtask

   initial begin
      int guard;
      int nxf;
      reset = 1'b1; enable = 1'b0; p_drdy = 1'b0; max_count = 32'd0;
      w_enable = 1'b0; w_drdy = 1'b0; w_max = 8'd0;
      model_reset();
      #2;
      check_all("rst_async");
      do_reset();

      // max_count=4 full rate: 4 words 0..3 then done.
      enable = 1'b1; max_count = 32'd4; p_drdy = 1'b1;
      for (int i = 0; i < 8; i++) tick("cnt4");
      chk("cnt4.final_count", 64'(out_count), 64'd4);
      chk("cnt4.final_done", 64'(done), 64'd1);

      // Stall: srdy and data held while drdy low and enable dropped.
      do_reset();
      max_count = 32'd0; p_drdy = 1'b0;
      tick("stall.start");
      enable = 1'b0;
      for (int i = 0; i < 5; i++) tick("stall.hold");
      chk("stall.held_data", 64'(p_data), 64'd0);
      p_drdy = 1'b1;
      tick("stall.xfer");
      tick("stall.idle");
      chk("stall.idle_srdy", 64'(p_srdy), 64'd0);

      // Asynchronous reset while p_data=7 is being offered.
      do_reset();
      enable = 1'b1; p_drdy = 1'b1;
      guard = 0;
      while (!(m_srdy && m_data == 16'd7) && guard < 30) begin
         tick("run7");
         guard++;
      end
      chk("run7.reached", 64'(guard < 30), 64'd1);
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      check_all("async_mid");
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Lower max_count below out_count while idle: goes to DONE.
      max_count = 32'd10; enable = 1'b1; p_drdy = 1'b1;
      guard = 0;
      while (m_cnt < 4 && guard < 30) begin
         tick("lower.run");
         guard++;
      end
      enable = 1'b0;
      tick("lower.last");
      chk("lower.count5", 64'(out_count), 64'd5);
      max_count = 32'd3; enable = 1'b1;
      for (int i = 0; i < 4; i++) tick("lower.done");
      chk("lower.done_flag", 64'(done), 64'd1);

      // Random traffic with occasional resets.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            max_count = 32'($urandom_range(0, 12));
            do_reset();
         end
         enable = 1'($urandom_range(0, 3) != 0);
         p_drdy = 1'($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 49) == 0) max_count = 32'($urandom_range(0, 12));
         tick("rand");
      end

      // Narrow instance: wrap of 4-bit data and saturation of 8-bit count.
      do_reset();
      enable = 1'b0;
      chk("wrap.reset_data", 64'(w_data), 64'd14);
      w_enable = 1'b1; w_drdy = 1'b1;
      nxf = 0;
      for (int i = 0; i < 4; i++) begin
         if (w_srdy) nxf++;
         tick("wrap.main");
         chk("wrap.srdy", 64'(w_srdy), 64'd1);
         chk("wrap.data", 64'(w_data), 64'((14 + nxf) % 16));
      end
      for (int i = 0; i < 300; i++) begin
         if (w_srdy) nxf++;
         tick("wrap.main");
      end
      chk("wrap.sat_count", 64'(w_count), 64'(nxf > 255 ? 255 : nxf));
      chk("wrap.seq_data", 64'(w_data), 64'((14 + nxf) % 16));
      chk("wrap.no_done", 64'(w_done), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sd_seq_source.md
Name: sd_seq_source

Overview:
- srdy/drdy producer that drives the consumer (c_) side of any sd block under test.
- Emits a registered, monotonically incrementing data sequence on a p_ interface, up to a programmable transfer count.
- Reports the number of completed transfers, so a bench can compare it against the DUT's output-side count.
- Used as the stimulus end of formal and simulation benches; obeys the sd protocol rules those benches check (no srdy retraction, data stable while stalled).

Parameters:
width, 16, data width of p_data
cnt_width, 32, width of max_count and out_count
start_value, 0, first data word emitted after reset (truncated to width)
lfsr_seed, 16'hACE1, throttle LFSR reset value; must be nonzero

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
enable  input  1  allows new transfers to start
max_count  input  cnt_width  total transfers to send; 0 = unlimited
p_srdy  output  1  producer data valid
p_drdy  input  1  downstream ready
p_data  output  width  producer data
out_count  output  cnt_width  completed transfers (p_srdy & p_drdy)
done  output  1  sticky; limit reached

Behaviour:
- Interface is fixed: one clock, clk; reset is asynchronous and active-high, named reset.
- All outputs are registered.
- Reset values: p_srdy=0, p_data=start_value, out_count=0, done=0, state=IDLE, lfsr=lfsr_seed.
- Transfer: occurs on any clk edge where p_srdy & p_drdy.
- limit_hit = (max_count != 0) && (out_count >= max_count). It is evaluated live, so a mid-run change of max_count takes effect at the next IDLE evaluation.
- gate = 1 unless the optional throttle is compiled in.
- State IDLE (p_srdy=0):
  - limit_hit -> DONE.
  - else enable & gate -> SEND; p_srdy=1 from the next cycle. Latency is 1 cycle from enable to p_srdy.
  - else stay in IDLE.
- State SEND (p_srdy=1):
  - No transfer: hold p_srdy and p_data. Changes on enable, gate or max_count are ignored; no retraction.
  - Transfer: out_count+1; p_data+1, wrapping mod 2^width.
    - If max_count != 0 and out_count+1 == max_count -> DONE, p_srdy=0.
    - else if enable & gate -> stay in SEND. This is back-to-back: one transfer per cycle is sustainable.
    - else -> IDLE, p_srdy=0.
- State DONE: done=1, p_srdy=0. Sticky; exits only on reset. enable and max_count are ignored.
- out_count saturates at all-ones and never wraps. The data sequence continues to wrap independently.
- Reset mid-transfer: all state returns to the reset values asynchronously. Any in-flight word is dropped; the next run restarts at start_value.
- max_count=1: exactly one word is sent, then DONE.

Optional Feature:
- Macro: SD_SEQ_THROTTLE_EN.
- Defined:
  - Adds input port throttle [3:0].
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every clk.
  - gate = (lfsr[3:0] >= throttle). throttle=0 gives full rate; larger values insert pseudo-random idle gaps between transfers.
  - Throttling only affects starting or continuing a word, never an already-asserted p_srdy.
- Undefined: no throttle port, no LFSR; gate is constant 1.

Test Plan:
- Reset, enable=1, max_count=4, p_drdy=1 -> p_srdy high cycles 1-4; p_data 0,1,2,3; out_count=4; done=1 in cycle 5; p_srdy=0 thereafter.
- p_drdy=0 for 5 cycles once p_srdy=1, enable dropped meanwhile -> p_srdy stays 1 and p_data=0 held; first transfer on p_drdy=1, then IDLE.
- width=4, start_value=14, max_count=0, p_drdy=1 -> p_data 14,15,0,1 (wrap); done stays 0.
- Reset asserted while p_srdy=1 with p_data=7 -> p_srdy=0, p_data=start_value, out_count=0, done=0 immediately, without waiting for a clk edge.
- max_count lowered from 10 to 3 while out_count=5 and enable toggled low then high -> DONE from IDLE; no further p_srdy.
- SD_SEQ_THROTTLE_EN, throttle=15, 1000 cycles, p_drdy=1 -> transfer rate well below 1/cycle and nonzero; sequence contiguous; no p_srdy retraction.
